// File: rtl/matmul_input_control_bisr_os_pkg.sv
// -----------------------------------------------------------------------------
// matmul_input_control_bisr_os_pkg
// Shared header for the output-stationary systolic matmul with built-in
// self-repair. Holds the default array geometry, operand width, index widths
// and the control FSM state encoding used by the input- and output-side
// control blocks.
// -----------------------------------------------------------------------------
package matmul_input_control_bisr_os_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_ROWS      = 4;
  localparam int DEF_COLS      = 4;
  localparam int DEF_K_DIM     = 4;
  localparam int DEF_NUM_RU    = 2;

  // Index width that never collapses to zero bits for a dimension of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_BITS_ROWS = idx_w(DEF_ROWS);
  localparam int DEF_NUM_BITS_COLS = idx_w(DEF_COLS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/matmul_ru_operand_select.sv
// -----------------------------------------------------------------------------
// matmul_ru_operand_select
// Operand tap for one recompute unit. Given the slot about to be emitted and
// the latched faulty-PE coordinate, it picks the A/B pair that PE (r,c) sees
// in that slot (k = t - r - c) and registers it, so the RU receives it in the
// same cycle as the PE.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_emit            a slot is being emitted at this edge
//   i_slot            slot index being emitted
//   i_en, i_row, i_col  latched RU enable and faulty-PE coordinate
//   i_a_mat, i_b_mat  flattened A (ROWS x K_DIM) and B (K_DIM x COLS)
//   o_a, o_b, o_valid registered RU operand pair and valid
// -----------------------------------------------------------------------------
module matmul_ru_operand_select
  import matmul_input_control_bisr_os_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int K_DIM         = DEF_K_DIM,
  parameter int NUM_BITS_ROWS = DEF_NUM_BITS_ROWS,
  parameter int NUM_BITS_COLS = DEF_NUM_BITS_COLS,
  parameter int CNT_W         = 4
)(
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_emit,
  input  logic [CNT_W-1:0]                 i_slot,
  input  logic                             i_en,
  input  logic [NUM_BITS_ROWS-1:0]         i_row,
  input  logic [NUM_BITS_COLS-1:0]         i_col,
  input  logic [ROWS*K_DIM*WORD_SIZE-1:0]  i_a_mat,
  input  logic [K_DIM*COLS*WORD_SIZE-1:0]  i_b_mat,
  output logic [WORD_SIZE-1:0]             o_a,
  output logic [WORD_SIZE-1:0]             o_b,
  output logic                             o_valid
);

  int                   w_k;
  logic                 w_in_array;
  logic                 w_vld;
  logic [WORD_SIZE-1:0] w_a;
  logic [WORD_SIZE-1:0] w_b;

  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  logic                 r_valid;

  always_comb begin
    // A coordinate outside the array (possible when the index width is
    // wider than the dimension) leaves this RU silent for the run.
    w_in_array = (int'(i_row) < ROWS) && (int'(i_col) < COLS);
    w_k        = int'(i_slot) - int'(i_row) - int'(i_col);
    w_vld      = i_emit && i_en && w_in_array && (w_k >= 0) && (w_k < K_DIM);
    w_a        = '0;
    w_b        = '0;
    // Constant-index muxes keep every part-select in range.
    for (int rr = 0; rr < ROWS; rr++)
      for (int kk = 0; kk < K_DIM; kk++)
        if (w_vld && int'(i_row) == rr && w_k == kk)
          w_a = i_a_mat[(rr*K_DIM+kk)*WORD_SIZE +: WORD_SIZE];
    for (int kk = 0; kk < K_DIM; kk++)
      for (int cc = 0; cc < COLS; cc++)
        if (w_vld && int'(i_col) == cc && w_k == kk)
          w_b = i_b_mat[(kk*COLS+cc)*WORD_SIZE +: WORD_SIZE];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_a     <= w_a;
      r_b     <= w_b;
      r_valid <= w_vld;
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_valid = r_valid;

endmodule

// File: rtl/matmul_input_control_bisr_os.sv
// -----------------------------------------------------------------------------
// matmul_input_control_bisr_os
// Input-side control for the output-stationary systolic matmul with BISR.
// Streams A into the left edge and B into the top edge, skewed one cycle per
// row/column, and mirrors each faulty PE's operands onto its recompute unit
// in the same cycle. No arithmetic; operands pass through untouched.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    run request, honoured only in IDLE
//   input_matrix             A[r][k] at (r*K_DIM+k)*WORD_SIZE
//   weight_matrix            B[k][c] at (k*COLS+c)*WORD_SIZE
//   ru_enable/_row/_col_mapping  RU repair assignment, latched at start
//   left_in_bus/left_valid   row operands
//   top_in_bus/top_valid     column operands
//   ru_left_in/ru_top_in/ru_input_valid  RU operands
//   ru_acc_clear             high with slot 0
//   busy, done               run in progress / one-cycle end pulse
// -----------------------------------------------------------------------------
module matmul_input_control_bisr_os
  import matmul_input_control_bisr_os_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int K_DIM         = DEF_K_DIM,
  parameter int NUM_RU        = DEF_NUM_RU,
  parameter int NUM_BITS_ROWS = idx_w(ROWS),
  parameter int NUM_BITS_COLS = idx_w(COLS)
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ROWS*K_DIM*WORD_SIZE-1:0]   input_matrix,
  input  logic [K_DIM*COLS*WORD_SIZE-1:0]   weight_matrix,
  input  logic [NUM_RU-1:0]                 ru_enable,
  input  logic [NUM_BITS_ROWS*NUM_RU-1:0]   ru_row_mapping,
  input  logic [NUM_BITS_COLS*NUM_RU-1:0]   ru_col_mapping,
  output logic [ROWS*WORD_SIZE-1:0]         left_in_bus,
  output logic [ROWS-1:0]                   left_valid,
  output logic [COLS*WORD_SIZE-1:0]         top_in_bus,
  output logic [COLS-1:0]                   top_valid,
  output logic [NUM_RU*WORD_SIZE-1:0]       ru_left_in,
  output logic [NUM_RU*WORD_SIZE-1:0]       ru_top_in,
  output logic [NUM_RU-1:0]                 ru_input_valid,
  output logic                              ru_acc_clear,
  output logic                              busy,
  output logic                              done
);

  localparam int T_FEED = K_DIM + ROWS + COLS - 2;
  localparam int CNT_W  = idx_w(T_FEED);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(T_FEED - 1);

  fsm_state_t                     r_state;
  logic [CNT_W-1:0]               r_slot;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_acc_clear;
  logic [NUM_RU-1:0]              r_ru_en;
  logic [NUM_BITS_ROWS*NUM_RU-1:0] r_ru_row;
  logic [NUM_BITS_COLS*NUM_RU-1:0] r_ru_col;

  // w_emit/w_slot describe the slot that becomes visible after this edge;
  // every operand register is loaded from them.
  logic                           w_emit;
  logic [CNT_W-1:0]               w_slot;
  logic [NUM_RU-1:0]              w_ru_en;
  logic [NUM_BITS_ROWS*NUM_RU-1:0] w_ru_row;
  logic [NUM_BITS_COLS*NUM_RU-1:0] w_ru_col;

  always_comb begin
    w_emit = 1'b0;
    w_slot = '0;
    case (r_state)
      ST_IDLE: w_emit = start;
      ST_FEED: if (r_slot != LAST_SLOT) begin
        w_emit = 1'b1;
        w_slot = r_slot + 1'b1;
      end
      default: ;
    endcase
  end

  // Slot 0 is produced on the accepting edge, before the latch holds the
  // mapping, so the live inputs are used while IDLE.
  assign w_ru_en  = (r_state == ST_IDLE) ? ru_enable      : r_ru_en;
  assign w_ru_row = (r_state == ST_IDLE) ? ru_row_mapping : r_ru_row;
  assign w_ru_col = (r_state == ST_IDLE) ? ru_col_mapping : r_ru_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_clear <= 1'b0;
      r_ru_en     <= '0;
      r_ru_row    <= '0;
      r_ru_col    <= '0;
    end else begin
      r_acc_clear <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state     <= ST_FEED;
          r_slot      <= '0;
          r_busy      <= 1'b1;
          r_acc_clear <= 1'b1;
          r_ru_en     <= ru_enable;
          r_ru_row    <= ru_row_mapping;
          r_ru_col    <= ru_col_mapping;
        end
        ST_FEED: begin
          if (r_slot == LAST_SLOT) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_slot <= w_slot;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign ru_acc_clear = r_acc_clear;

  // Left edge: row r carries A[r][t-r].
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    int                   w_k;
    logic                 w_vld;
    logic [WORD_SIZE-1:0] w_dat;
    logic                 r_vld;
    logic [WORD_SIZE-1:0] r_dat;

    always_comb begin
      w_k   = int'(w_slot) - r;
      w_vld = w_emit && (w_k >= 0) && (w_k < K_DIM);
      w_dat = '0;
      for (int kk = 0; kk < K_DIM; kk++)
        if (w_vld && w_k == kk)
          w_dat = input_matrix[(r*K_DIM+kk)*WORD_SIZE +: WORD_SIZE];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else begin
        r_vld <= w_vld;
        r_dat <= w_dat;
      end
    end

    assign left_valid[r]                          = r_vld;
    assign left_in_bus[r*WORD_SIZE +: WORD_SIZE]  = r_dat;
  end

  // Top edge: column c carries B[t-c][c].
  for (genvar c = 0; c < COLS; c++) begin : g_col
    int                   w_k;
    logic                 w_vld;
    logic [WORD_SIZE-1:0] w_dat;
    logic                 r_vld;
    logic [WORD_SIZE-1:0] r_dat;

    always_comb begin
      w_k   = int'(w_slot) - c;
      w_vld = w_emit && (w_k >= 0) && (w_k < K_DIM);
      w_dat = '0;
      for (int kk = 0; kk < K_DIM; kk++)
        if (w_vld && w_k == kk)
          w_dat = weight_matrix[(kk*COLS+c)*WORD_SIZE +: WORD_SIZE];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else begin
        r_vld <= w_vld;
        r_dat <= w_dat;
      end
    end

    assign top_valid[c]                          = r_vld;
    assign top_in_bus[c*WORD_SIZE +: WORD_SIZE]  = r_dat;
  end

  for (genvar i = 0; i < NUM_RU; i++) begin : g_ru
    matmul_ru_operand_select #(
      .WORD_SIZE     (WORD_SIZE),
      .ROWS          (ROWS),
      .COLS          (COLS),
      .K_DIM         (K_DIM),
      .NUM_BITS_ROWS (NUM_BITS_ROWS),
      .NUM_BITS_COLS (NUM_BITS_COLS),
      .CNT_W         (CNT_W)
    ) u_sel (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_emit  (w_emit),
      .i_slot  (w_slot),
      .i_en    (w_ru_en[i]),
      .i_row   (w_ru_row[i*NUM_BITS_ROWS +: NUM_BITS_ROWS]),
      .i_col   (w_ru_col[i*NUM_BITS_COLS +: NUM_BITS_COLS]),
      .i_a_mat (input_matrix),
      .i_b_mat (weight_matrix),
      .o_a     (ru_left_in[i*WORD_SIZE +: WORD_SIZE]),
      .o_b     (ru_top_in[i*WORD_SIZE +: WORD_SIZE]),
      .o_valid (ru_input_valid[i])
    );
  end

endmodule

// File: tb/tb_matmul_input_control_bisr_os.sv
module tb_matmul_input_control_bisr_os;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start;
  logic [255:0] a_mat, b_mat;
  logic [191:0] a3_mat;
  logic [1:0]   ru_en;
  logic [3:0]   ru_row, ru_col;

  logic [63:0] lb, tb_bus;
  logic [3:0]  lv, tv;
  logic [31:0] rul, rut;
  logic [1:0]  ruv;
  logic        acc, busy, done;

  logic [47:0] lb3;
  logic [2:0]  lv3;
  logic [63:0] tb3;
  logic [3:0]  tv3;
  logic [31:0] rul3, rut3;
  logic [1:0]  ruv3;
  logic        acc3, busy3, done3;

  matmul_input_control_bisr_os dut (
    .clk(clk), .rst(rst), .start(start),
    .input_matrix(a_mat), .weight_matrix(b_mat),
    .ru_enable(ru_en), .ru_row_mapping(ru_row), .ru_col_mapping(ru_col),
    .left_in_bus(lb), .left_valid(lv), .top_in_bus(tb_bus), .top_valid(tv),
    .ru_left_in(rul), .ru_top_in(rut), .ru_input_valid(ruv),
    .ru_acc_clear(acc), .busy(busy), .done(done)
  );

  // Three-row variant: a 2-bit row index can name row 3, which is off-array.
  matmul_input_control_bisr_os #(.ROWS(3), .NUM_BITS_ROWS(2)) dut3 (
    .clk(clk), .rst(rst), .start(start),
    .input_matrix(a3_mat), .weight_matrix(b_mat),
    .ru_enable(ru_en), .ru_row_mapping(ru_row), .ru_col_mapping(ru_col),
    .left_in_bus(lb3), .left_valid(lv3), .top_in_bus(tb3), .top_valid(tv3),
    .ru_left_in(rul3), .ru_top_in(rut3), .ru_input_valid(ruv3),
    .ru_acc_clear(acc3), .busy(busy3), .done(done3)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0]  c_lv[32], c_tv[32];
  logic [63:0] c_lb[32], c_tb[32];
  logic [1:0]  c_ruv[32], c3_ruv[32];
  logic [31:0] c_rul[32], c_rut[32];
  logic        c_acc[32], c_busy[32], c_done[32], c3_done[32];

  typedef struct {
    int          c;
    logic [3:0]  lv, tv;
    logic [63:0] lb, tb;
    logic        busy, done;
  } edge_vec_t;

  typedef struct {
    int          run;
    int          c;
    logic [1:0]  ruv;
    logic [31:0] rul, rut;
    logic        acc;
  } ru_vec_t;

  edge_vec_t ev[6];
  ru_vec_t   rv[11];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] snap();
    return {lv, tv, lb, tb_bus, ruv, rul, rut, acc, busy, done};
  endfunction

  // Entered just after a negedge: raises start, then captures n cycles.
  // Cycle c is the one in which slot c of the accepted run is visible.
  task automatic run_capture(input int n, input logic [31:0] st_mask, input int map_c,
                             input logic [1:0] m_en, input logic [3:0] m_row,
                             input logic [3:0] m_col, input int rst_c);
    start = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      c_lv[c] = lv;  c_tv[c] = tv;  c_lb[c] = lb;  c_tb[c] = tb_bus;
      c_ruv[c] = ruv; c_rul[c] = rul; c_rut[c] = rut;
      c_acc[c] = acc; c_busy[c] = busy; c_done[c] = done;
      c3_ruv[c] = ruv3; c3_done[c] = done3;
      start = st_mask[c];
      rst   = (c == rst_c);
      if (c == map_c) begin
        ru_en = m_en; ru_row = m_row; ru_col = m_col;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_ru_table(input int run);
    for (int i = 0; i < 11; i++) begin
      if (rv[i].run == run) begin
        chk($sformatf("run%0d_ruv_c%0d", run, rv[i].c), c_ruv[rv[i].c], rv[i].ruv);
        chk($sformatf("run%0d_rul_c%0d", run, rv[i].c), c_rul[rv[i].c], rv[i].rul);
        chk($sformatf("run%0d_rut_c%0d", run, rv[i].c), c_rut[rv[i].c], rv[i].rut);
        chk($sformatf("run%0d_acc_c%0d", run, rv[i].c), c_acc[rv[i].c], rv[i].acc);
      end
    end
  endtask

  function automatic int count_done(input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += int'(c_done[c]);
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int bad;
    int nb;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        a_mat[(r*4+k)*16 +: 16] = 16'(16*r + k + 1);
        b_mat[(r*4+k)*16 +: 16] = 16'(16*r + k + 'h81);
      end
    a3_mat = a_mat[191:0];

    ev[0] = '{c:0,  lv:4'b0001, tv:4'b0001, lb:64'h0000_0000_0000_0001,
              tb:64'h0000_0000_0000_0081, busy:1'b1, done:1'b0};
    ev[1] = '{c:3,  lv:4'b1111, tv:4'b1111, lb:64'h0031_0022_0013_0004,
              tb:64'h0084_0093_00A2_00B1, busy:1'b1, done:1'b0};
    ev[2] = '{c:5,  lv:4'b1100, tv:4'b1100, lb:64'h0033_0024_0000_0000,
              tb:64'h00A4_00B3_0000_0000, busy:1'b1, done:1'b0};
    ev[3] = '{c:9,  lv:4'b0000, tv:4'b0000, lb:64'h0, tb:64'h0, busy:1'b1, done:1'b0};
    ev[4] = '{c:10, lv:4'b0000, tv:4'b0000, lb:64'h0, tb:64'h0, busy:1'b0, done:1'b1};
    ev[5] = '{c:11, lv:4'b0000, tv:4'b0000, lb:64'h0, tb:64'h0, busy:1'b0, done:1'b0};

    rv[0]  = '{run:2, c:0, ruv:2'b00, rul:32'h0,  rut:32'h0,  acc:1'b1};
    rv[1]  = '{run:2, c:1, ruv:2'b00, rul:32'h0,  rut:32'h0,  acc:1'b0};
    rv[2]  = '{run:2, c:3, ruv:2'b01, rul:32'h11, rut:32'h83, acc:1'b0};
    rv[3]  = '{run:2, c:4, ruv:2'b01, rul:32'h12, rut:32'h93, acc:1'b0};
    rv[4]  = '{run:2, c:5, ruv:2'b01, rul:32'h13, rut:32'hA3, acc:1'b0};
    rv[5]  = '{run:2, c:6, ruv:2'b01, rul:32'h14, rut:32'hB3, acc:1'b0};
    rv[6]  = '{run:2, c:7, ruv:2'b00, rul:32'h0,  rut:32'h0,  acc:1'b0};
    rv[7]  = '{run:3, c:5, ruv:2'b00, rul:32'h0,  rut:32'h0,  acc:1'b0};
    rv[8]  = '{run:3, c:6, ruv:2'b11, rul:32'h0031_0031, rut:32'h0084_0084, acc:1'b0};
    rv[9]  = '{run:3, c:7, ruv:2'b11, rul:32'h0032_0032, rut:32'h0094_0094, acc:1'b0};
    rv[10] = '{run:3, c:9, ruv:2'b11, rul:32'h0034_0034, rut:32'h00B4_00B4, acc:1'b0};

    rst = 1'b1; start = 1'b0; ru_en = '0; ru_row = '0; ru_col = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", snap(), '0);
    rst = 1'b0;
    @(negedge clk);

    // Run 1: plain feed, no RU.
    run_capture(12, 32'h0, -1, 2'b00, 4'h0, 4'h0, -1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("run1_lv_c%0d", ev[i].c),   c_lv[ev[i].c],   ev[i].lv);
      chk($sformatf("run1_tv_c%0d", ev[i].c),   c_tv[ev[i].c],   ev[i].tv);
      chk($sformatf("run1_lb_c%0d", ev[i].c),   c_lb[ev[i].c],   ev[i].lb);
      chk($sformatf("run1_tb_c%0d", ev[i].c),   c_tb[ev[i].c],   ev[i].tb);
      chk($sformatf("run1_busy_c%0d", ev[i].c), c_busy[ev[i].c], ev[i].busy);
      chk($sformatf("run1_done_c%0d", ev[i].c), c_done[ev[i].c], ev[i].done);
    end
    bad = 0; nb = 0;
    for (int c = 0; c < 12; c++) begin
      if (c_ruv[c] != 2'b00 || c_rul[c] != 0 || c_rut[c] != 0) bad++;
      nb += int'(c_busy[c]);
    end
    chk("run1_ru_silent", 32'(bad), 32'd0);
    chk("run1_busy_cycles", 32'(nb), 32'd10);
    chk("run1_done_count", 32'(count_done(12)), 32'd1);
    @(negedge clk);

    // Run 2: RU0 on PE(1,2).
    ru_en = 2'b01; ru_row = 4'b0001; ru_col = 4'b0010;
    run_capture(12, 32'h0, -1, 2'b00, 4'h0, 4'h0, -1);
    check_ru_table(2);
    bad = 0;
    for (int c = 0; c < 12; c++)
      if ((c < 3 || c > 6) && c_ruv[c][0]) bad++;
    chk("run2_ru0_outside_window", 32'(bad), 32'd0);
    @(negedge clk);

    // Run 3: both RUs on PE(3,3).
    ru_en = 2'b11; ru_row = 4'b1111; ru_col = 4'b1111;
    run_capture(12, 32'h0, -1, 2'b00, 4'h0, 4'h0, -1);
    check_ru_table(3);
    @(negedge clk);

    // Run 4: remap + start mid-run and in DONE (ignored), start after done.
    ru_en = 2'b01; ru_row = 4'b0001; ru_col = 4'b0010;
    run_capture(24, 32'h0000_0C04, 2, 2'b11, 4'b0000, 4'b0000, -1);
    chk("run4_ruv_c3", c_ruv[3], 2'b01);
    chk("run4_rul_c3", c_rul[3], 32'h11);
    chk("run4_rut_c3", c_rut[3], 32'h83);
    chk("run4_rul_c6", c_rul[6], 32'h14);
    chk("run4_rut_c6", c_rut[6], 32'hB3);
    chk("run4_done_c10", c_done[10], 1'b1);
    chk("run4_busy_c11", c_busy[11], 1'b0);
    chk("run4_busy_c12", c_busy[12], 1'b1);
    chk("run4_acc_c12", c_acc[12], 1'b1);
    chk("run4_lv_c12", c_lv[12], 4'b0001);
    chk("run4_ruv_c12", c_ruv[12], 2'b11);
    chk("run4_rul_c12", c_rul[12], 32'h0001_0001);
    chk("run4_rut_c12", c_rut[12], 32'h0081_0081);
    chk("run4_done_c22", c_done[22], 1'b1);
    chk("run4_done_count", 32'(count_done(24)), 32'd2);
    @(negedge clk);

    // Run 5: reset during slot 4.
    ru_en = 2'b01; ru_row = 4'b0001; ru_col = 4'b0010;
    run_capture(14, 32'h0, -1, 2'b00, 4'h0, 4'h0, 4);
    chk("run5_busy_c4", c_busy[4], 1'b1);
    chk("run5_ruv_c4", c_ruv[4], 2'b01);
    chk("run5_after_rst", {c_lv[5], c_tv[5], c_lb[5], c_tb[5], c_ruv[5], c_rul[5],
                           c_rut[5], c_acc[5], c_busy[5], c_done[5]}, '0);
    chk("run5_done_count", 32'(count_done(14)), 32'd0);
    chk("run5_busy_c13", c_busy[13], 1'b0);
    @(negedge clk);

    // Run 6: RU0 on row 3; off-array for the three-row instance.
    ru_en = 2'b01; ru_row = 4'b0011; ru_col = 4'b0000;
    run_capture(12, 32'h0, -1, 2'b00, 4'h0, 4'h0, -1);
    bad = 0; nb = 0;
    for (int c = 0; c < 12; c++) begin
      if (c3_ruv[c][0]) bad++;
      nb += int'(c3_done[c]);
    end
    chk("run6_r3_ru0_silent", 32'(bad), 32'd0);
    chk("run6_r3_done_count", 32'(nb), 32'd1);
    chk("run6_r4_ruv_c3", c_ruv[3], 2'b01);
    chk("run6_r4_rul_c3", c_rul[3], 32'h31);
    chk("run6_r4_rut_c3", c_rut[3], 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_input_control_bisr_os.md
# matmul_input_control_bisr_os

Input-side control path for the output-stationary systolic matmul with built-in self-repair. Streams a stored input matrix A (ROWS×K_DIM) into the array's left edge and a weight matrix B (K_DIM×COLS) into its top edge, skewed one cycle per row and column. It also duplicates each faulty PE's operand stream onto its assigned recompute unit (RU) in the same cycle that PE receives it. RU results therefore line up with array results on the output side.

## Interface
- WORD_SIZE, 16, operand width
- ROWS, 4, array rows
- COLS, 4, array columns
- K_DIM, 4, inner dimension
- NUM_RU, 2, recompute units
- NUM_BITS_ROWS, $clog2(ROWS), row-index width
- NUM_BITS_COLS, $clog2(COLS), column-index width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- input_matrix  in  ROWS*K_DIM*WORD_SIZE  A[r][k] at bits (r*K_DIM+k)*WORD_SIZE; stable while busy
- weight_matrix  in  K_DIM*COLS*WORD_SIZE  B[k][c] at bits (k*COLS+c)*WORD_SIZE; stable while busy
- ru_enable  in  NUM_RU  RU i repairs a PE
- ru_row_mapping  in  NUM_BITS_ROWS*NUM_RU  faulty-PE row for RU i
- ru_col_mapping  in  NUM_BITS_COLS*NUM_RU  faulty-PE column for RU i
- left_in_bus  out  ROWS*WORD_SIZE  row operands
- left_valid  out  ROWS  per-row operand valid
- top_in_bus  out  COLS*WORD_SIZE  column operands
- top_valid  out  COLS  per-column operand valid
- ru_left_in  out  NUM_RU*WORD_SIZE  RU A operand
- ru_top_in  out  NUM_RU*WORD_SIZE  RU B operand
- ru_input_valid  out  NUM_RU  RU operand valid
- ru_acc_clear  out  1  RU accumulator clear
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse

## Operation
- FSM states:
  - IDLE: on start, latch ru_enable and the mappings, set slot counter t=0, go to FEED.
  - FEED: emit slot t every cycle. At t = T_FEED−1, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- T_FEED = K_DIM+ROWS+COLS−2. The counter is wide enough for T_FEED−1.
- Row r at slot t: when 0 ≤ t−r < K_DIM, drive A[r][t−r] with left_valid[r]=1. Otherwise drive data 0 with valid 0.
- Column c at slot t: when 0 ≤ t−c < K_DIM, drive B[t−c][c] with top_valid[c]=1. Otherwise drive 0 with valid 0.
- RU i mapped to PE (r,c): let k = t−r−c. When the latched enable is set and 0 ≤ k < K_DIM, drive ru_left_in[i]=A[r][k] and ru_top_in[i]=B[k][c] with ru_input_valid[i]=1. Otherwise drive 0 with valid 0.
- ru_acc_clear is high together with slot 0.
- The mapping is latched at start. Changes to the mapping during a run have no effect.
- A latched row ≥ ROWS or column ≥ COLS disables that RU for the run.
- Two RUs mapped to the same PE both receive identical streams.
- start while busy or in DONE is ignored. There is no queueing.
- No arithmetic is performed; operands pass through unmodified.

## Timing
- All outputs are registered.
- Reset value of every output is 0, and the FSM returns to IDLE.
- Reset mid-run aborts the run. No done pulse is produced.
- Slot 0 is visible in the cycle after the edge that accepts start. Slot t is visible t cycles later.
- busy is high while slots 0..T_FEED−1 are visible.
- done is high in the next cycle, with busy=0 and all valids 0.
- A new start is accepted in the cycle after done.
- Minimum start-to-start spacing is T_FEED+2 cycles.

## Structure
- The shared header holds ROWS, COLS, K_DIM, NUM_RU, WORD_SIZE, index widths, and the FSM state encodings (IDLE/FEED/DONE). The output-side control block uses the same values.
- One sub-module, matmul_ru_operand_select. It is instantiated NUM_RU times and does the following:
  - takes slot t, the latched row/column/enable, and both matrices;
  - computes k;
  - produces the registered RU operand pair and valid.
- The skewed edge feeders stay in the top level as generate loops.

## Test plan
Defaults (4×4, K_DIM=4, NUM_RU=2), with A[r][k]=16r+k+1 and B[k][c]=16k+c+0x81.

1. Reset then start, no RU enabled:
   - 10 slots; busy high for 10 cycles, done in cycle 11.
   - Slot 0: row 0 = 1, column 0 = 0x81, all other valids 0.
   - Slot 5: row 2 = A[2][3] = 0x24, column 3 = B[2][3] = 0xA4.
2. RU0 enabled at PE (1,2):
   - Slots 3..6: ru_input_valid[0]=1 with (A[1][0],B[0][2]) = (0x11,0x83) through (A[1][3],B[3][2]) = (0x14,0xB3).
   - Valid is 0 in every other slot.
   - ru_acc_clear is high with slot 0.
3. RU0 and RU1 both mapped to PE (3,3): identical streams in slots 6..9.
4. Mapping changed and start pulsed again mid-run: the stream is unchanged and done fires once. A start issued the cycle after done begins a fresh run.
5. rst asserted in slot 4: the next cycle shows all outputs 0 and busy 0, and no done pulse follows.
6. RU0 enabled with latched row ≥ ROWS (NUM_BITS_ROWS widened at ROWS=3): ru_input_valid[0] stays 0 for the whole run.
